// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, entry layout and FSM states for alu_result_stage (optional ALU_RESULT_PARITY_EN)
package alu_pkg;

    localparam int ALU_W = 8;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_CMP = 2'd3;

    // One captured result as it sits in a storage slot
    typedef struct packed {
        logic [ALU_W-1:0] y;
        logic             c;
        logic             z;
        logic [1:0]       op;
`ifdef ALU_RESULT_PARITY_EN
        logic             p;
`endif
    } alu_entry_t;

    // Occupancy of the stage: bit 1 = main valid, bit 0 = skid valid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } stage_state_t;

    // Carry/borrow is only meaningful for the arithmetic ops
    function automatic logic carry_kept(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_skid_entry.sv
// rtl/alu_skid_entry.sv - one result storage slot with load, hold and clear
module alu_skid_entry
    import alu_pkg::*;
#(
    parameter int ENTRY_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic [ENTRY_W-1:0] i_data,
    output logic [ENTRY_W-1:0] o_data
);

    logic [ENTRY_W-1:0] r_data;

    // Clear wins over load; otherwise the slot holds its contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_clear) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU result stage with 2-entry skid buffer (optional ALU_RESULT_PARITY_EN adds OUT_P)
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN_Y,
    input  logic             IN_C,
    input  logic [1:0]       IN_OP,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT_Y,
    output logic             OUT_C,
    output logic             OUT_Z,
    output logic [1:0]       OUT_OP,
`ifdef ALU_RESULT_PARITY_EN
    output logic             OUT_P,
`endif
    output logic [CNT_W-1:0] RES_CNT
);

`ifdef ALU_RESULT_PARITY_EN
    localparam int P_W = 1;
`else
    localparam int P_W = 0;
`endif
    localparam int ENTRY_W = WIDTH + 4 + P_W;

    stage_state_t       r_state;
    stage_state_t       w_next_state;
    logic               r_in_ready;
    logic [CNT_W-1:0]   r_res_cnt;

    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_main_load;
    logic               w_main_from_skid;
    logic               w_main_clear;
    logic               w_skid_load;
    logic               w_skid_clear;

    logic [ENTRY_W-1:0] w_in_entry;
    logic [ENTRY_W-1:0] w_main_d;
    logic [ENTRY_W-1:0] w_main_q;
    logic [ENTRY_W-1:0] w_skid_q;

    assign w_in_fire  = IN_VALID & r_in_ready;
    assign w_out_fire = r_state[1] & OUT_READY;

    // Flags are derived from the incoming word at capture time, not at the output
`ifdef ALU_RESULT_PARITY_EN
    assign w_in_entry = {IN_Y, IN_C & carry_kept(IN_OP), ~|IN_Y, IN_OP, ^IN_Y};
`else
    assign w_in_entry = {IN_Y, IN_C & carry_kept(IN_OP), ~|IN_Y, IN_OP};
`endif

    assign w_main_d = w_main_from_skid ? w_skid_q : w_in_entry;

    // Occupancy register and the registered input-ready that mirrors skid emptiness
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= ~w_next_state[0];
        end
    end

    // Next occupancy and slot controls from the two handshakes
    always_comb begin
        w_next_state     = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_main_clear     = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_main_load  = 1'b1;
                    w_next_state = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_load = 1'b1;
                end else if (w_in_fire) begin
                    w_skid_load  = 1'b1;
                    w_next_state = ST_FULL;
                end else if (w_out_fire) begin
                    w_main_clear = 1'b1;
                    w_next_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // IN_READY is low here, so only the drain path can move
                if (w_out_fire) begin
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_skid_clear     = 1'b1;
                    w_next_state     = ST_ONE;
                end
            end
            default: begin
                w_next_state = ST_EMPTY;
            end
        endcase
    end

    alu_skid_entry #(
        .ENTRY_W (ENTRY_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_d),
        .o_data  (w_main_q)
    );

    alu_skid_entry #(
        .ENTRY_W (ENTRY_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_in_entry),
        .o_data  (w_skid_q)
    );

    // Delivered-result counter, free-running wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_cnt <= '0;
        end else if (w_out_fire) begin
            r_res_cnt <= r_res_cnt + CNT_W'(1);
        end
    end

    assign IN_READY  = r_in_ready;
    assign OUT_VALID = r_state[1];
    assign OUT_Y     = w_main_q[ENTRY_W-1 -: WIDTH];
    assign OUT_C     = w_main_q[P_W+3];
    assign OUT_Z     = w_main_q[P_W+2];
    assign OUT_OP    = w_main_q[P_W+1 -: 2];
`ifdef ALU_RESULT_PARITY_EN
    assign OUT_P     = w_main_q[0];
`endif
    assign RES_CNT   = r_res_cnt;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage against a queue model
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_y;
    logic       in_c;
    logic [1:0] in_op;
    logic       out_ready;

    logic       in_ready, out_valid, out_c, out_z;
    logic [7:0] out_y;
    logic [1:0] out_op;
    logic [7:0] res_cnt;
    logic       in_ready4, out_valid4, out_c4, out_z4;
    logic [7:0] out_y4;
    logic [1:0] out_op4;
    logic [3:0] res_cnt4;
`ifdef ALU_RESULT_PARITY_EN
    logic       out_p, out_p4;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] y;
        logic       c;
        logic [1:0] op;
    } ent_t;

    ent_t q[$];
    int   cnt = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(8), .CNT_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .IN_Y      (in_y),
        .IN_C      (in_c),
        .IN_OP     (in_op),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_Y     (out_y),
        .OUT_C     (out_c),
        .OUT_Z     (out_z),
        .OUT_OP    (out_op),
`ifdef ALU_RESULT_PARITY_EN
        .OUT_P     (out_p),
`endif
        .RES_CNT   (res_cnt)
    );

    alu_result_stage #(.WIDTH(8), .CNT_W(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready4),
        .IN_Y      (in_y),
        .IN_C      (in_c),
        .IN_OP     (in_op),
        .OUT_VALID (out_valid4),
        .OUT_READY (out_ready),
        .OUT_Y     (out_y4),
        .OUT_C     (out_c4),
        .OUT_Z     (out_z4),
        .OUT_OP    (out_op4),
`ifdef ALU_RESULT_PARITY_EN
        .OUT_P     (out_p4),
`endif
        .RES_CNT   (res_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every visible output with what the queue model says should be there
    task automatic check_all();
        logic [31:0] ec;
        chk("in_ready",   in_ready,   q.size() < 2);
        chk("in_ready4",  in_ready4,  q.size() < 2);
        chk("out_valid",  out_valid,  q.size() > 0);
        chk("out_valid4", out_valid4, q.size() > 0);
        chk("res_cnt",    res_cnt,    cnt % 256);
        chk("res_cnt4",   res_cnt4,   cnt % 16);
        if (q.size() > 0) begin
            ec = (q[0].op == 2'd1 || q[0].op == 2'd2) ? q[0].c : 0;
            chk("out_y",  out_y,  q[0].y);
            chk("out_c",  out_c,  ec);
            chk("out_z",  out_z,  q[0].y == 8'd0);
            chk("out_op", out_op, q[0].op);
            chk("out_y4", out_y4, q[0].y);
`ifdef ALU_RESULT_PARITY_EN
            chk("out_p",  out_p,  ^q[0].y);
`endif
        end
    endtask

    // One clock: decide the handshakes from pre-edge values, update the model, then check
    task automatic cycle();
        bit   inf, outf;
        ent_t e;
        inf  = in_valid && (q.size() < 2);
        outf = out_ready && (q.size() > 0);
        e.y  = in_y;
        e.c  = in_c;
        e.op = in_op;
        @(posedge clk);
        if (outf) begin
            void'(q.pop_front());
            cnt++;
        end
        if (inf) q.push_back(e);
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [7:0] y, input logic [1:0] op, input logic c);
        in_valid = v;
        in_y     = y;
        in_op    = op;
        in_c     = c;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_y",     out_y,     8'h00);
        chk("rst_out_c",     out_c,     1'b0);
        chk("rst_out_z",     out_z,     1'b0);
        chk("rst_out_op",    out_op,    2'd0);
        chk("rst_res_cnt",   res_cnt,   8'd0);
`ifdef ALU_RESULT_PARITY_EN
        chk("rst_out_p",     out_p,     1'b0);
`endif
        rst = 1'b0;
        cycle();

        // Single transfer with zero word and carry on ADD
        drive(1'b1, 8'h00, 2'd1, 1'b1);
        out_ready = 1'b1;
        cycle();
        chk("single_valid", out_valid, 1'b1);
        chk("single_z",     out_z,     1'b1);
        chk("single_c",     out_c,     1'b1);
        chk("single_op",    out_op,    2'd1);
        drive(1'b0, 8'hAA, 2'd3, 1'b1);
        cycle();
        chk("single_cnt",   res_cnt,   8'd1);

        // Back-pressure fill
        out_ready = 1'b0;
        drive(1'b1, 8'h3C, 2'd0, 1'b1);
        cycle();
        drive(1'b1, 8'h05, 2'd2, 1'b1);
        cycle();
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_y",        out_y,    8'h3C);
        chk("bp_c",        out_c,    1'b0);
        drive(1'b1, 8'h77, 2'd1, 1'b1);
        cycle();
        chk("bp_hold_y",   out_y,    8'h3C);

        // Drain in order
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        out_ready = 1'b1;
        cycle();
        chk("drain_y",     out_y,    8'h05);
        chk("drain_c",     out_c,    1'b1);
        chk("drain_ready", in_ready, 1'b1);
        cycle();
        chk("drain_cnt",   res_cnt,  8'd3);

        // Fill to FULL, then reset between edges
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 2'd1, 1'b0);
        cycle();
        drive(1'b1, 8'h22, 2'd2, 1'b1);
        cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready",  in_ready,  1'b1);
        chk("arst_res_cnt",   res_cnt,   8'd0);
        q.delete();
        cnt = 0;
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
        cycle();

        // Streaming 1..20 with both sides always ready
        out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 8'(i), 2'(i % 4), 1'(i % 2));
            cycle();
            chk("stream_valid", out_valid, 1'b1);
            chk("stream_y",     out_y,     32'(i));
            if (cnt == 17) chk("wrap_cnt4", res_cnt4, 4'd1);
        end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        cycle();
        chk("stream_cnt",  res_cnt,  8'd20);
        chk("stream_cnt4", res_cnt4, 4'd4);

        // Random traffic, data toggling even while IN_VALID is low
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom), 1'($urandom));
            if ($urandom_range(0, 7) == 0) in_y = 8'h00;
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("final_empty", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
